// File: rtl/wb_mem_arbiter.sv
// wb_mem_arbiter: two-master round-robin arbiter in front of one wishbone
// memory slave. The owner keeps the grant for its whole cyc, so bursts
// are never split, and at least one idle cycle separates owners.
// Optional stalled-strobe timeout: define WB_MEM_ARB_TIMEOUT_EN.
module wb_mem_arbiter #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    i_m0_we,
   input  logic                    i_m0_stb,
   input  logic                    i_m0_cyc,
   input  logic [DATA_WIDTH/8-1:0] i_m0_sel,
   input  logic [ADDR_WIDTH-1:0]   i_m0_adr,
   input  logic [DATA_WIDTH-1:0]   i_m0_dat,
   output logic [DATA_WIDTH-1:0]   o_m0_dat,
   output logic                    o_m0_ack,
   output logic                    o_m0_int,
   input  logic                    i_m1_we,
   input  logic                    i_m1_stb,
   input  logic                    i_m1_cyc,
   input  logic [DATA_WIDTH/8-1:0] i_m1_sel,
   input  logic [ADDR_WIDTH-1:0]   i_m1_adr,
   input  logic [DATA_WIDTH-1:0]   i_m1_dat,
   output logic [DATA_WIDTH-1:0]   o_m1_dat,
   output logic                    o_m1_ack,
   output logic                    o_m1_int,
   output logic                    o_s_we,
   output logic                    o_s_stb,
   output logic                    o_s_cyc,
   output logic [DATA_WIDTH/8-1:0] o_s_sel,
   output logic [ADDR_WIDTH-1:0]   o_s_adr,
   output logic [DATA_WIDTH-1:0]   o_s_dat,
   input  logic [DATA_WIDTH-1:0]   i_s_dat,
   input  logic                    i_s_ack,
   input  logic                    i_s_int,
   output logic [1:0]              o_grant,
   output logic                    o_timeout
);

   typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

   state_t state;
   state_t state_nxt;
   logic   r_last;
   logic   to_hit;

   // Next owner: a sole requester wins; on a tie the master not served last wins.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (i_m0_cyc && (!i_m1_cyc || r_last))
               state_nxt = GNT0;
            else if (i_m1_cyc)
               state_nxt = GNT1;
         end
         GNT0: if (!i_m0_cyc) state_nxt = IDLE;
         GNT1: if (!i_m1_cyc) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Arbiter state, last-served master and registered one-hot grant.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         r_last  <= 1'b1;
         o_grant <= '0;
      end else begin
         state   <= state_nxt;
         o_grant <= {state_nxt == GNT1, state_nxt == GNT0};
         if (state == GNT0 && state_nxt == IDLE)
            r_last <= 1'b0;
         else if (state == GNT1 && state_nxt == IDLE)
            r_last <= 1'b1;
      end
   end

`ifdef WB_MEM_ARB_TIMEOUT_EN
   logic [31:0] r_to_cnt;
   logic        owner_req;
   logic        stalled;

   // Owner currently presenting a strobe inside its cycle.
   always_comb begin
      owner_req = 1'b0;
      case (state)
         GNT0:    owner_req = i_m0_cyc & i_m0_stb;
         GNT1:    owner_req = i_m1_cyc & i_m1_stb;
         default: owner_req = 1'b0;
      endcase
   end

   assign stalled = owner_req & ~i_s_ack;
   assign to_hit  = stalled && (r_to_cnt == 32'(TIMEOUT_CYCLES - 1));

   // Stall counter; the forced ack counts as a completed beat and restarts it.
   always_ff @(posedge clk) begin
      if (rst || !stalled || to_hit || (state_nxt != state))
         r_to_cnt <= '0;
      else
         r_to_cnt <= r_to_cnt + 32'd1;
   end
`else
   assign to_hit = 1'b0;
`endif

   assign o_timeout = to_hit;
   assign o_m0_int  = i_s_int;
   assign o_m1_int  = i_s_int;

   // Route the owner's bus to the slave and the slave response back to the owner.
   always_comb begin
      o_s_we   = 1'b0;
      o_s_stb  = 1'b0;
      o_s_cyc  = 1'b0;
      o_s_sel  = '0;
      o_s_adr  = '0;
      o_s_dat  = '0;
      o_m0_ack = 1'b0;
      o_m0_dat = '0;
      o_m1_ack = 1'b0;
      o_m1_dat = '0;
      case (state)
         GNT0: begin
            o_s_we   = i_m0_we;
            o_s_stb  = i_m0_stb & ~to_hit;
            o_s_cyc  = i_m0_cyc;
            o_s_sel  = i_m0_sel;
            o_s_adr  = i_m0_adr;
            o_s_dat  = i_m0_dat;
            o_m0_ack = i_s_ack | to_hit;
            o_m0_dat = to_hit ? '0 : i_s_dat;
         end
         GNT1: begin
            o_s_we   = i_m1_we;
            o_s_stb  = i_m1_stb & ~to_hit;
            o_s_cyc  = i_m1_cyc;
            o_s_sel  = i_m1_sel;
            o_s_adr  = i_m1_adr;
            o_s_dat  = i_m1_dat;
            o_m1_ack = i_s_ack | to_hit;
            o_m1_dat = to_hit ? '0 : i_s_dat;
         end
         default: ;
      endcase
   end

endmodule
